// File: rtl/bvh_leaf_fetch_scheduler_if.sv
// rtl/bvh_leaf_fetch_scheduler_if.sv - request, leaf-lookup and primitive stream signals of the leaf fetch scheduler
interface bvh_leaf_fetch_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 16,
    parameter int PRIM_W  = 32,
    parameter int CNT_W   = 8
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*IDX_W-1:0] req_index;
    logic [NUM_REQ-1:0]       req_ready;
    logic [IDX_W-1:0]         leaf_index;
    logic [PRIM_W-1:0]        leaf_start_prim;
    logic [CNT_W-1:0]         leaf_num_prims;
    logic                     prim_valid;
    logic                     prim_ready;
    logic [PRIM_W-1:0]        prim_index;
    logic [GW-1:0]            prim_req_id;
    logic                     prim_last;
    logic [NUM_REQ-1:0]       done_valid;

    modport master (
        input  req_valid, req_index, leaf_start_prim, leaf_num_prims, prim_ready,
        output req_ready, leaf_index, prim_valid, prim_index, prim_req_id, prim_last, done_valid
    );

    modport slave (
        output req_valid, req_index, leaf_start_prim, leaf_num_prims, prim_ready,
        input  req_ready, leaf_index, prim_valid, prim_index, prim_req_id, prim_last, done_valid
    );
endinterface

// File: rtl/bvh_leaf_fetch_scheduler.sv
// rtl/bvh_leaf_fetch_scheduler.sv - round-robin sharing of one BVH leaf lookup unit, streaming leaf primitive indices
module bvh_leaf_fetch_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 16,
    parameter int PRIM_W  = 32,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    bvh_leaf_fetch_scheduler_if.master   bus
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_EMIT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GW-1:0]      r_rr_ptr;
    logic [GW-1:0]      r_grant;
    logic [GW-1:0]      w_pick;
    logic [GW-1:0]      w_rr_nxt;
    logic               w_any;
    logic [IDX_W-1:0]   r_leaf_index;
    logic [PRIM_W-1:0]  r_cur;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_prim_valid;
    logic               r_prim_last;
    logic [NUM_REQ-1:0] r_done_valid;
    logic               w_fire;
    logic               w_prim_valid_nxt;
    logic               w_prim_last_nxt;
    logic [NUM_REQ-1:0] w_done_nxt;
    logic [NUM_REQ-1:0] w_req_ready;

    // Scan downwards so the requester closest to (at or after) r_rr_ptr wins.
    always_comb begin
        w_pick = r_rr_ptr;
        w_any  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_pick = GW'((int'(r_rr_ptr) + k) % NUM_REQ);
                w_any  = 1'b1;
            end
        end
    end

    assign w_rr_nxt = (int'(w_pick) == NUM_REQ - 1) ? '0 : w_pick + 1'b1;
    assign w_fire   = r_prim_valid & bus.prim_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_state_nxt = S_LOOKUP;
            S_LOOKUP: w_state_nxt = (bus.leaf_num_prims == '0) ? S_DONE : S_EMIT;
            S_EMIT:   if (w_fire && r_prim_last) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered stream/done outputs, plus the combinational grant pulse.
    always_comb begin
        w_req_ready      = '0;
        w_prim_valid_nxt = 1'b0;
        w_prim_last_nxt  = 1'b0;
        w_done_nxt       = '0;
        if (r_state == S_IDLE && w_any) begin
            w_req_ready = NUM_REQ'(1) << w_pick;
        end
        case (r_state)
            S_LOOKUP: begin
                w_prim_valid_nxt = (bus.leaf_num_prims != '0);
                w_prim_last_nxt  = (bus.leaf_num_prims == CNT_W'(1));
                if (bus.leaf_num_prims == '0) begin
                    w_done_nxt = NUM_REQ'(1) << r_grant;
                end
            end
            S_EMIT: begin
                if (w_fire && r_prim_last) begin
                    w_done_nxt = NUM_REQ'(1) << r_grant;
                end else begin
                    w_prim_valid_nxt = 1'b1;
                    w_prim_last_nxt  = w_fire ? (r_remaining == CNT_W'(2)) : r_prim_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_leaf_index <= '0;
            r_cur        <= '0;
            r_remaining  <= '0;
            r_prim_valid <= 1'b0;
            r_prim_last  <= 1'b0;
            r_done_valid <= '0;
        end else begin
            r_prim_valid <= w_prim_valid_nxt;
            r_prim_last  <= w_prim_last_nxt;
            r_done_valid <= w_done_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_pick;
                        r_leaf_index <= bus.req_index[w_pick*IDX_W +: IDX_W];
                        r_rr_ptr     <= w_rr_nxt;
                    end
                end
                S_LOOKUP: begin
                    r_cur       <= bus.leaf_start_prim;
                    r_remaining <= bus.leaf_num_prims;
                end
                S_EMIT: begin
                    if (w_fire) begin
                        r_cur       <= r_cur + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.leaf_index  = r_leaf_index;
    assign bus.prim_valid  = r_prim_valid;
    assign bus.prim_index  = r_cur;
    assign bus.prim_req_id = r_grant;
    assign bus.prim_last   = r_prim_last;
    assign bus.done_valid  = r_done_valid;
endmodule

// File: tb/tb_bvh_leaf_fetch_scheduler.sv
// tb/tb_bvh_leaf_fetch_scheduler.sv - self-checking bench for bvh_leaf_fetch_scheduler against a transaction-timeline model
module tb_bvh_leaf_fetch_scheduler;
    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 16;
    localparam int PRIM_W  = 32;
    localparam int CNT_W   = 8;
    localparam int GW      = $clog2(NUM_REQ);
    localparam int FAR     = 1 << 30;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bvh_leaf_fetch_scheduler_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .PRIM_W(PRIM_W), .CNT_W(CNT_W)) bus ();

    bvh_leaf_fetch_scheduler #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .PRIM_W(PRIM_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Leaf unit stub: indices 0x8000..0x800F use programmable entries, other leaves derive from the index.
    logic [PRIM_W-1:0] ovr_start [0:15];
    logic [CNT_W-1:0]  ovr_num   [0:15];

    function automatic logic [PRIM_W-1:0] leaf_start(input logic [IDX_W-1:0] idx);
        if (!idx[IDX_W-1]) return '0;
        if (idx[14:4] == 11'd0) return ovr_start[idx[3:0]];
        return {idx, ~idx};
    endfunction

    function automatic logic [CNT_W-1:0] leaf_num(input logic [IDX_W-1:0] idx);
        if (!idx[IDX_W-1]) return '0;
        if (idx[14:4] == 11'd0) return ovr_num[idx[3:0]];
        return {4'd0, idx[3:0]};
    endfunction

    always_comb begin
        bus.leaf_start_prim = leaf_start(bus.leaf_index);
        bus.leaf_num_prims  = leaf_num(bus.leaf_index);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    // Requester and stream model state
    int               cyc = 0;
    bit               pend_valid [NUM_REQ];
    logic [IDX_W-1:0] pend_idx   [NUM_REQ];
    int               m_rr, m_free, m_emit_start, m_done_cycle, m_owner, m_beats_left;
    logic [PRIM_W-1:0] m_cur;
    logic [IDX_W-1:0] m_leaf_exp;
    int               m_exp_beats = 0;
    int               beats_accepted = 0;
    int               grant_log [$];
    int               ready_mode = 0;
    int               stall_left = 0;
    bit               rst_drive = 1'b1;
    bit               skip = 1'b1;
    bit               after_reset = 1'b0;

    task automatic post(input int k, input logic [IDX_W-1:0] idx);
        pend_valid[k] = 1'b1;
        pend_idx[k]   = idx;
    endtask

    task automatic sample();
        logic [NUM_REQ-1:0] exp_rr;
        int g;
        bit exp_valid;
        int nb;
        exp_rr = '0;
        g = -1;
        if (cyc >= m_free) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int c;
                c = (m_rr + k) % NUM_REQ;
                if (g < 0 && pend_valid[c]) g = c;
            end
        end
        if (g >= 0) exp_rr[g] = 1'b1;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rr));
        check("leaf_index", 64'(bus.leaf_index), 64'(m_leaf_exp));
        if (after_reset) begin
            check("rst_prim_index", 64'(bus.prim_index), 64'd0);
            check("rst_prim_req_id", 64'(bus.prim_req_id), 64'd0);
            after_reset = 1'b0;
        end
        exp_valid = (m_beats_left > 0) && (cyc >= m_emit_start);
        check("prim_valid", 64'(bus.prim_valid), 64'(exp_valid));
        check("prim_last", 64'(bus.prim_last), 64'(exp_valid && m_beats_left == 1));
        if (exp_valid) begin
            check("prim_index", 64'(bus.prim_index), 64'(m_cur));
            check("prim_req_id", 64'(bus.prim_req_id), 64'(m_owner));
            if (bus.prim_ready) begin
                beats_accepted++;
                m_cur = m_cur + 1'b1;
                m_beats_left--;
                if (m_beats_left == 0) begin
                    m_done_cycle = cyc + 1;
                    m_free       = cyc + 2;
                end
            end
        end
        check("done_valid", 64'(bus.done_valid),
              (cyc == m_done_cycle) ? (64'd1 << m_owner) : 64'd0);
        if (g >= 0) begin
            pend_valid[g] = 1'b0;
            grant_log.push_back(g);
            m_rr         = (g + 1) % NUM_REQ;
            m_owner      = g;
            m_leaf_exp   = pend_idx[g];
            m_cur        = leaf_start(pend_idx[g]);
            nb           = int'(leaf_num(pend_idx[g]));
            m_beats_left = nb;
            m_exp_beats += nb;
            if (nb == 0) begin
                m_done_cycle = cyc + 2;
                m_free       = cyc + 3;
            end else begin
                m_emit_start = cyc + 2;
                m_free       = FAR;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        reset = rst_drive;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_valid[k] = pend_valid[k];
            bus.req_index[k*IDX_W +: IDX_W] = pend_idx[k];
        end
        case (ready_mode)
            0: bus.prim_ready = 1'b1;
            1: bus.prim_ready = 1'($urandom_range(0, 1));
            default: begin
                if (stall_left > 0 && bus.prim_valid) begin
                    bus.prim_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.prim_ready = 1'b1;
                end
            end
        endcase
        #1;
        if (!skip) sample();
        cyc++;
    endtask

    task automatic model_reset();
        m_rr = 0; m_free = 0; m_emit_start = FAR; m_done_cycle = -10;
        m_owner = 0; m_beats_left = 0; m_cur = '0; m_leaf_exp = '0;
    endtask

    task automatic do_reset();
        rst_drive = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) pend_valid[k] = 1'b0;
        skip = 1'b1;
        cycle();
        model_reset();
        skip = 1'b0;
        after_reset = 1'b1;
        cycle();
        rst_drive = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            cycle();
            n++;
            busy = (m_beats_left > 0) || (cyc < m_free);
            for (int k = 0; k < NUM_REQ; k++) if (pend_valid[k]) busy = 1'b1;
        end
        check("drain_idle", 64'(busy), 64'd0);
    endtask

    function automatic logic [IDX_W-1:0] rand_idx();
        logic [IDX_W-1:0] r;
        r = IDX_W'($urandom);
        r[4] = 1'b1;
        r[IDX_W-1] = ($urandom_range(0, 4) != 0);
        return r;
    endfunction

    initial begin
        int b0, g0, n;
        for (int i = 0; i < 16; i++) begin
            ovr_start[i] = PRIM_W'(32'h100 * i);
            ovr_num[i]   = CNT_W'(i % 5);
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            pend_valid[k] = 1'b0;
            pend_idx[k]   = '0;
        end
        bus.req_valid  = '0;
        bus.req_index  = '0;
        bus.prim_ready = 1'b1;
        model_reset();
        do_reset();
        cycle();

        // Single leaf, three beats
        ovr_start[0] = 32'h10; ovr_num[0] = 8'd3;
        b0 = beats_accepted;
        post(0, 16'h8000);
        drain(50);
        check("t1_beats", 64'(beats_accepted - b0), 64'd3);
        check("t1_grant", 64'(grant_log[$]), 64'd0);

        // Non-leaf index
        b0 = beats_accepted;
        post(2, 16'h0005);
        drain(50);
        check("t2_beats", 64'(beats_accepted - b0), 64'd0);
        check("t2_grant", 64'(grant_log[$]), 64'd2);

        // All cores requesting continuously after a fresh reset
        do_reset();
        for (int i = 8; i < 12; i++) begin
            ovr_start[i] = PRIM_W'(32'h4000 + i);
            ovr_num[i]   = CNT_W'(i - 7);
        end
        g0 = grant_log.size();
        n = 0;
        while (grant_log.size() < g0 + 5 && n < 300) begin
            for (int k = 0; k < NUM_REQ; k++)
                if (!pend_valid[k]) post(k, IDX_W'(16'h8008 + k));
            cycle();
            n++;
        end
        for (int k = 0; k < NUM_REQ; k++) pend_valid[k] = 1'b0;
        drain(100);
        check("t3_count", 64'(grant_log.size() >= g0 + 5), 64'd1);
        for (int i = 0; i < 5; i++)
            if (g0 + i < grant_log.size())
                check("t3_order", 64'(grant_log[g0+i]), 64'(i % NUM_REQ));

        // Backpressure on beat 0
        ovr_start[4] = 32'h777; ovr_num[4] = 8'd2;
        ready_mode = 2; stall_left = 3;
        b0 = beats_accepted;
        post(1, 16'h8004);
        drain(50);
        check("t4_beats", 64'(beats_accepted - b0), 64'd2);
        check("t4_stall_used", 64'(stall_left), 64'd0);
        ready_mode = 0;

        // Index wrap and maximum count
        ovr_start[5] = 32'hFFFF_FFFF; ovr_num[5] = 8'd2;
        b0 = beats_accepted;
        post(3, 16'h8005);
        drain(50);
        check("t5_wrap_beats", 64'(beats_accepted - b0), 64'd2);
        ovr_start[6] = 32'h1000; ovr_num[6] = 8'd255;
        b0 = beats_accepted;
        post(0, 16'h8006);
        drain(400);
        check("t5_max_beats", 64'(beats_accepted - b0), 64'd255);

        // Reset in the middle of a stream
        ovr_start[7] = 32'h200; ovr_num[7] = 8'd4;
        post(2, 16'h8007);
        b0 = beats_accepted;
        n = 0;
        while (beats_accepted == b0 && n < 20) begin
            cycle();
            n++;
        end
        check("t6_one_beat", 64'(beats_accepted - b0), 64'd1);
        do_reset();
        cycle();
        b0 = beats_accepted;
        post(1, 16'h8000);
        drain(50);
        check("t6_fresh_grant", 64'(grant_log[$]), 64'd1);
        check("t6_fresh_beats", 64'(beats_accepted - b0), 64'd3);

        // Randomized traffic with random backpressure
        ready_mode = 1;
        b0 = beats_accepted;
        g0 = m_exp_beats;
        for (int t = 0; t < 600; t++) begin
            for (int k = 0; k < NUM_REQ; k++)
                if (!pend_valid[k] && $urandom_range(0, 3) == 0) post(k, rand_idx());
            cycle();
        end
        drain(3000);
        check("rand_beats", 64'(beats_accepted - b0), 64'(m_exp_beats - g0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
